// File: rtl/spi_host_pkg.sv
// Shared definitions for the SPI Wishbone host.
// Holds the FSM state encoding, the idle levels of the SPI lines (mode 0)
// and helpers that size a frame from the address width and dummy-bit count.
package spi_host_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    localparam int   DATA_BITS = 8;

    // Mode 0: sck idles low; the select line idles high; mosi parks low.
    localparam logic SCK_IDLE  = 1'b0;
    localparam logic SS_IDLE   = 1'b1;
    localparam logic MOSI_IDLE = 1'b0;

    // Header is {we, adr}.
    function automatic int hdr_bits(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic int write_frame_bits(input int addr_width);
        return hdr_bits(addr_width) + DATA_BITS;
    endfunction

    function automatic int read_frame_bits(input int addr_width, input int dummy_bits);
        return hdr_bits(addr_width) + dummy_bits + DATA_BITS;
    endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// Serial clock generator for the SPI host.
// A half-period down-counter produces a tick every CLK_DIV cycles while
// enabled. When sck_en is also high each tick toggles sck; rise/fall flag the
// clock edge on which sck will go high/low. Disabling returns sck low and
// reloads the counter so the next enable starts a fresh low phase.
//
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   en             count half-periods (SETUP and SHIFT)
//   sck_en         allow sck to toggle on ticks (SHIFT only)
//   sck            registered serial clock
//   tick           end of a half-period on this edge
//   rise, fall     sck goes high / low on this edge
module spi_sck_gen
    import spi_host_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en,
    input  logic sck_en,
    output logic sck,
    output logic tick,
    output logic rise,
    output logic fall
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == '0);
    assign rise = tick && sck_en && !sck;
    assign fall = tick && sck_en && sck;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt <= RELOAD;
            sck <= SCK_IDLE;
        end else if (!en) begin
            cnt <= RELOAD;
            sck <= SCK_IDLE;
        end else if (cnt == '0) begin
            cnt <= RELOAD;
            if (sck_en) begin
                sck <= ~sck;
            end
        end else begin
            cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/spi_wishbone_host.sv
// Wishbone slave that turns each 8-bit single read or write into one SPI
// mode-0 frame towards a remote spi_wishbone_bridge.
//   write frame: {1, adr} then 8 data bits
//   read frame : {0, adr}, READ_DUMMY_BITS zero bits, then 8 bits from miso
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   cyc_i, stb_i, we_i Wishbone request; adr_i remote address; dat_i write data
//   ack_o              one-cycle completion pulse (suppressed if cyc_i is gone)
//   err_o, rty_o       tied low
//   dat_o              read data, updated when a read frame ends
//   spi_ss_n, spi_sck, spi_mosi, spi_miso   SPI wires
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | ss_n high, waiting for cyc_i & stb_i
// ST_SETUP | ss_n low, first bit on mosi, CLK_DIV cycles before shifting
// ST_SHIFT | per bit: sck low CLK_DIV cycles, high CLK_DIV cycles
// ST_HOLD  | sck low, ss_n still low for CLK_DIV cycles; exit raises ss_n + ack
// ST_GAP   | ss_n high for GAP_CYCLES before the next request is accepted
module spi_wishbone_host
    import spi_host_pkg::*;
#(
    parameter int ADDR_WIDTH      = 23,
    parameter int CLK_DIV         = 2,
    parameter int READ_DUMMY_BITS = 8,
    parameter int GAP_CYCLES      = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cyc_i,
    input  logic                  stb_i,
    input  logic [ADDR_WIDTH-1:0] adr_i,
    input  logic                  we_i,
    input  logic [7:0]            dat_i,
    output logic                  ack_o,
    output logic                  err_o,
    output logic                  rty_o,
    output logic [7:0]            dat_o,
    output logic                  spi_ss_n,
    output logic                  spi_sck,
    output logic                  spi_mosi,
    input  logic                  spi_miso
);

    localparam int HDR     = hdr_bits(ADDR_WIDTH);
    localparam int WR_BITS = write_frame_bits(ADDR_WIDTH);
    localparam int RD_BITS = read_frame_bits(ADDR_WIDTH, READ_DUMMY_BITS);
    localparam int FW      = RD_BITS;
    localparam int BCW     = $clog2(FW + 1);
    localparam int TMAX    = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int TW      = (TMAX > 1) ? $clog2(TMAX) : 1;

    state_t          state;
    logic [FW-1:0]   sr_load;
    // Holds the bits still to go after the one currently on mosi.
    logic [FW-2:0]   sr;
    logic [BCW-1:0]  nbits_load;
    logic [BCW-1:0]  bits_left;
    logic [TW-1:0]   timer;
    logic            we_q;
    logic [7:0]      rx;
    logic            gen_en;
    logic            shift_en;
    logic            sck_tick;
    logic            sck_rise;
    logic            sck_fall;

    assign err_o = 1'b0;
    assign rty_o = 1'b0;

    // Frame image, MSB first; unused tail bits stay zero so mosi is low
    // during dummy and read-data bits.
    always_comb begin
        sr_load = '0;
        sr_load[FW-1 -: HDR] = {we_i, adr_i};
        if (we_i) begin
            sr_load[FW-1-HDR -: DATA_BITS] = dat_i;
        end
    end

    assign nbits_load = we_i ? BCW'(WR_BITS) : BCW'(RD_BITS);
    assign gen_en     = (state == ST_SETUP) || (state == ST_SHIFT);
    assign shift_en   = (state == ST_SHIFT);

    spi_sck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sck_gen (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en     (gen_en),
        .sck_en (shift_en),
        .sck    (spi_sck),
        .tick   (sck_tick),
        .rise   (sck_rise),
        .fall   (sck_fall)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= ST_IDLE;
            spi_ss_n  <= SS_IDLE;
            spi_mosi  <= MOSI_IDLE;
            ack_o     <= 1'b0;
            dat_o     <= '0;
            sr        <= '0;
            bits_left <= '0;
            timer     <= '0;
            we_q      <= 1'b0;
            rx        <= '0;
        end else begin
            ack_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cyc_i && stb_i) begin
                        we_q      <= we_i;
                        sr        <= sr_load[FW-2:0];
                        spi_mosi  <= sr_load[FW-1];
                        bits_left <= nbits_load;
                        spi_ss_n  <= 1'b0;
                        state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (sck_tick) begin
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // Count on the rising edge so the falling edge of the
                    // last bit already sees zero and can leave SHIFT.
                    if (sck_rise) begin
                        bits_left <= bits_left - BCW'(1);
                    end
                    if (sck_fall) begin
                        rx       <= {rx[6:0], spi_miso};
                        spi_mosi <= sr[FW-2];
                        sr       <= {sr[FW-3:0], 1'b0};
                        if (bits_left == '0) begin
                            timer <= TW'(CLK_DIV - 1);
                            state <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (timer == '0) begin
                        spi_ss_n <= 1'b1;
                        spi_mosi <= MOSI_IDLE;
                        // A master that abandoned the cycle gets no ack, but
                        // the frame already went out so read data is kept.
                        ack_o    <= cyc_i;
                        if (!we_q) begin
                            dat_o <= rx;
                        end
                        timer <= TW'(GAP_CYCLES - 1);
                        state <= ST_GAP;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                ST_GAP: begin
                    if (timer == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_wishbone_host.sv
// Scoreboard bench: stimulus pushes expected acks and expected mosi frames;
// per-DUT monitors pop and compare when ack_o pulses or ss_n rises.
// Instance 0 uses defaults; instance 1 uses CLK_DIV=1, READ_DUMMY_BITS=0.
module tb_spi_wishbone_host;

    typedef struct {
        logic       chk_dat;
        logic [7:0] dat;
        int         lat;
        int         req;
    } ack_t;

    typedef struct {
        logic [63:0] bits;
        int          nbits;
        int          low;
    } frm_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc_cnt = 0;
    int   checks = 0;
    int   errors = 0;

    logic        cyc [2];
    logic        stb [2];
    logic        we  [2];
    logic [22:0] adr [2];
    logic [7:0]  dat [2];
    logic [7:0]  miso_byte [2];
    logic        ack [2];
    logic        err [2];
    logic        rty [2];
    logic [7:0]  dato [2];
    logic        ss_n [2];
    logic        sck [2];
    logic        mosi [2];

    ack_t ack_q [2][$];
    frm_t frm_q [2][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt = cyc_cnt + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s actual=missing/unexpected event required=expected event", nm);
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int CD = (g == 0) ? 2 : 1;
        localparam int RD = (g == 0) ? 8 : 0;

        logic        miso_r = 1'b0;
        int          nb = 0;
        int          last_fall = 0;
        int          last_rise = 0;
        int          gap_len = 0;
        int          ack_cnt = 0;
        logic [63:0] bits = '0;

        spi_wishbone_host #(
            .ADDR_WIDTH      (23),
            .CLK_DIV         (CD),
            .READ_DUMMY_BITS (RD),
            .GAP_CYCLES      (2)
        ) u_dut (
            .clk_i    (clk),
            .rst_ni   (rst_n),
            .cyc_i    (cyc[g]),
            .stb_i    (stb[g]),
            .adr_i    (adr[g]),
            .we_i     (we[g]),
            .dat_i    (dat[g]),
            .ack_o    (ack[g]),
            .err_o    (err[g]),
            .rty_o    (rty[g]),
            .dat_o    (dato[g]),
            .spi_ss_n (ss_n[g]),
            .spi_sck  (sck[g]),
            .spi_mosi (mosi[g]),
            .spi_miso (miso_r)
        );

        always @(negedge ss_n[g]) begin
            if (rst_n) begin
                gap_len   = cyc_cnt - last_rise;
                last_fall = cyc_cnt;
                nb        = 0;
                bits      = '0;
            end
        end

        // Bridge model: capture mosi on rising sck, present read data on
        // miso from the rising edge of each data bit until it is sampled.
        always @(posedge sck[g]) begin
            int idx;
            if (!ss_n[g]) begin
                bits = {bits[62:0], mosi[g]};
                idx  = nb;
                nb   = nb + 1;
                if (idx >= 24 + RD && idx < 32 + RD)
                    miso_r = miso_byte[g][7 - (idx - 24 - RD)];
                else
                    miso_r = 1'b0;
            end
        end

        always @(posedge ss_n[g]) begin
            frm_t e;
            if (rst_n) begin
                last_rise = cyc_cnt;
                if (frm_q[g].size() == 0) begin
                    fail("frame_unexpected");
                end else begin
                    e = frm_q[g].pop_front();
                    chk("frame_bits", bits, e.bits);
                    chk("frame_nbits", 64'(nb), 64'(e.nbits));
                    chk("ss_n_low_cycles", 64'(cyc_cnt - last_fall), 64'(e.low));
                end
            end
        end

        always @(negedge clk) begin
            ack_t e;
            if (rst_n && ack[g]) begin
                ack_cnt = ack_cnt + 1;
                chk("err_rty", {62'd0, err[g], rty[g]}, 64'd0);
                if (ack_q[g].size() == 0) begin
                    fail("ack_spurious");
                end else begin
                    e = ack_q[g].pop_front();
                    if (e.lat > 0)
                        chk("ack_latency", 64'(cyc_cnt - e.req), 64'(e.lat));
                    if (e.chk_dat)
                        chk("dat_o", 64'(dato[g]), 64'(e.dat));
                end
            end
        end
    end

    task automatic req(input int g, input logic w, input logic [22:0] a, input logic [7:0] d);
        @(negedge clk);
        cyc[g] = 1'b1;
        stb[g] = 1'b1;
        we[g]  = w;
        adr[g] = a;
        dat[g] = d;
    endtask

    task automatic exp_ack(input int g, input logic cd, input logic [7:0] d, input int lat);
        ack_t e;
        e.chk_dat = cd;
        e.dat     = d;
        e.lat     = lat;
        e.req     = cyc_cnt;
        ack_q[g].push_back(e);
    endtask

    task automatic exp_frame(input int g, input logic [63:0] b, input int n, input int low);
        frm_t e;
        e.bits  = b;
        e.nbits = n;
        e.low   = low;
        frm_q[g].push_back(e);
    endtask

    task automatic wait_ack(input int g);
        int n = 0;
        while (!ack[g] && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!ack[g]) fail("ack_timeout");
    endtask

    task automatic drop_and_idle(input int g);
        cyc[g] = 1'b0;
        stb[g] = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_bits0(input int target);
        int n = 0;
        while (g_dut[0].nb < target && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (g_dut[0].nb < target) fail("bit_wait_timeout");
    endtask

    task automatic wait_ss_high0();
        int n = 0;
        while (!ss_n[0] && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!ss_n[0]) fail("ss_n_rise_timeout");
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0;
            adr[i] = '0;   dat[i] = '0;   miso_byte[i] = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_ss_n", 64'(ss_n[i]), 64'd1);
            chk("rst_sck",  64'(sck[i]),  64'd0);
            chk("rst_mosi", 64'(mosi[i]), 64'd0);
            chk("rst_ack",  64'(ack[i]),  64'd0);
            chk("rst_dat_o", 64'(dato[i]), 64'd0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Write 0x012345 <- 0xA5: 32 bits, ack after 1+2+128+2 cycles.
        req(0, 1'b1, 23'h012345, 8'hA5);
        exp_ack(0, 1'b0, 8'h00, 133);
        exp_frame(0, 64'h812345A5, 32, 132);
        wait_ack(0);
        drop_and_idle(0);

        // Read 0x7FFFFF -> 0x3C: 40 bits, ack after 1+2+160+2 cycles.
        miso_byte[0] = 8'h3C;
        req(0, 1'b0, 23'h7FFFFF, 8'h00);
        exp_ack(0, 1'b1, 8'h3C, 165);
        exp_frame(0, 64'h7FFFFF0000, 40, 164);
        wait_ack(0);
        drop_and_idle(0);

        // A write must leave the last read data on dat_o.
        req(0, 1'b1, 23'h000010, 8'h5A);
        exp_ack(0, 1'b0, 8'h00, 133);
        exp_frame(0, 64'h8000105A, 32, 132);
        wait_ack(0);
        chk("dat_o_hold", 64'(dato[0]), 64'h3C);
        drop_and_idle(0);

        // Back-to-back with stb held: second request rides the GAP.
        req(0, 1'b1, 23'h000003, 8'h11);
        exp_ack(0, 1'b0, 8'h00, 133);
        exp_frame(0, 64'h80000311, 32, 132);
        wait_ack(0);
        we[0] = 1'b0;
        adr[0] = 23'h000004;
        miso_byte[0] = 8'h96;
        exp_ack(0, 1'b1, 8'h96, 0);
        exp_frame(0, 64'h0000040000, 40, 164);
        @(negedge clk);
        wait_ack(0);
        chk("gap_len", 64'(g_dut[0].gap_len), 64'd3);
        drop_and_idle(0);

        // Asynchronous reset in the middle of a read.
        miso_byte[0] = 8'h55;
        req(0, 1'b0, 23'h0000AA, 8'h00);
        @(negedge clk);
        wait_bits0(10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_ss_n", 64'(ss_n[0]), 64'd1);
        chk("midrst_sck",  64'(sck[0]),  64'd0);
        chk("midrst_ack",  64'(ack[0]),  64'd0);
        cyc[0] = 1'b0;
        stb[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_ss_n_held", 64'(ss_n[0]), 64'd1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Clean frame after the reset.
        req(0, 1'b1, 23'h000055, 8'hC3);
        exp_ack(0, 1'b0, 8'h00, 133);
        exp_frame(0, 64'h800055C3, 32, 132);
        wait_ack(0);
        drop_and_idle(0);

        // cyc_i dropped at bit 5: full frame on the wire, no ack.
        req(0, 1'b1, 23'h000077, 8'h3E);
        exp_frame(0, 64'h8000773E, 32, 132);
        @(negedge clk);
        wait_bits0(5);
        cyc[0] = 1'b0;
        stb[0] = 1'b0;
        wait_ss_high0();
        repeat (6) @(negedge clk);

        // CLK_DIV=1, no dummy bits: read 0x000001 -> 0xFF after 1+1+64+1.
        miso_byte[1] = 8'hFF;
        req(1, 1'b0, 23'h000001, 8'h00);
        exp_ack(1, 1'b1, 8'hFF, 67);
        exp_frame(1, 64'h00000100, 32, 66);
        wait_ack(1);
        drop_and_idle(1);

        chk("ack_count_0", 64'(g_dut[0].ack_cnt), 64'd6);
        chk("ack_count_1", 64'(g_dut[1].ack_cnt), 64'd1);
        chk("ack_q_left_0", 64'(ack_q[0].size()), 64'd0);
        chk("ack_q_left_1", 64'(ack_q[1].size()), 64'd0);
        chk("frm_q_left_0", 64'(frm_q[0].size()), 64'd0);
        chk("frm_q_left_1", 64'(frm_q[1].size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
